// File: rtl/chain_swap_pkg.sv
// Shared types and constants for the chain swap sequencer.
package chain_swap_pkg;

  // Sequencer states.
  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StDrain  = 3'd1,
    StSwitch = 3'd2,
    StSettle = 3'd3,
    StDone   = 3'd4
  } state_e;

  // Path mux select values.
  localparam logic CHAIN_BUF = 1'b0;
  localparam logic CHAIN_INV = 1'b1;

  // Timer width: clog2(max(quiet_timeout, settle)), at least one bit.
  // Holds both QUIET_TIMEOUT-1 and SETTLE-1.
  function automatic int unsigned timer_width(input int unsigned quiet_timeout,
                                              input int unsigned settle);
    int unsigned m;
    int unsigned w;
    m = (quiet_timeout > settle) ? quiet_timeout : settle;
    w = $clog2(m);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/chain_swap_timer.sv
// Loadable up/down counter shared by the drain timeout and the settle countdown.
module chain_swap_timer #(
  parameter int unsigned Width = 4,
  parameter int unsigned Limit = 15
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             load_i,
  input  logic [Width-1:0] load_val_i,
  input  logic             inc_i,
  input  logic             dec_i,
  output logic             is_zero_o,
  output logic             at_limit_o
);

  logic [Width-1:0] cnt_q, cnt_d;

  // Next count: clear beats load beats inc beats dec; dec saturates at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (load_i) begin
      cnt_d = load_val_i;
    end else if (inc_i) begin
      cnt_d = cnt_q + Width'(1);
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - Width'(1);
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Status flags decoded from the current count.
  always_comb begin
    is_zero_o  = (cnt_q == '0);
    at_limit_o = (cnt_q == Width'(Limit));
  end

endmodule

// File: rtl/chain_swap_ctrl.sv
// Hitless swap sequencer between the buffer chain and the double-inverter chain.
// Waits for a quiet launch cycle, flips the path mux, gates capture enables
// while the new chain settles, then acknowledges.
module chain_swap_ctrl
  import chain_swap_pkg::*;
#(
  parameter int unsigned N_CAP         = 11,
  parameter int unsigned SETTLE        = 2,
  parameter int unsigned QUIET_TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             swap_req,
  input  logic             swap_to,
  input  logic             quiet,
  input  logic [N_CAP-1:0] cap_mask,
  output logic             sel,
  output logic [N_CAP-1:0] cap_en,
  output logic             busy,
  output logic             swap_ack,
  output logic             err
);

  localparam int unsigned     TW         = timer_width(QUIET_TIMEOUT, SETTLE);
  localparam logic [TW-1:0]   SettleLoad = TW'(SETTLE - 1);

  state_e state_q, state_d;
  logic   tgt_q, tgt_d;
  logic   sel_q, sel_d;
  logic   err_q, err_d;

  logic tmr_clr, tmr_load, tmr_inc, tmr_dec;
  logic tmr_zero, tmr_limit;

  chain_swap_timer #(
    .Width (TW),
    .Limit (QUIET_TIMEOUT - 1)
  ) u_timer (
    .clk_i      (clk),
    .rst_i      (rst),
    .clr_i      (tmr_clr),
    .load_i     (tmr_load),
    .load_val_i (SettleLoad),
    .inc_i      (tmr_inc),
    .dec_i      (tmr_dec),
    .is_zero_o  (tmr_zero),
    .at_limit_o (tmr_limit)
  );

  // Next-state, select update and timer control.
  always_comb begin
    state_d  = state_q;
    tgt_d    = tgt_q;
    sel_d    = sel_q;
    err_d    = 1'b0;
    tmr_clr  = 1'b0;
    tmr_load = 1'b0;
    tmr_inc  = 1'b0;
    tmr_dec  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (swap_req) begin
          if (swap_to != sel_q) begin
            tgt_d   = swap_to;
            tmr_clr = 1'b1;
            state_d = StDrain;
          end else begin
            // Already on the requested chain: acknowledge without switching.
            state_d = StDone;
          end
        end
      end
      StDrain: begin
        // quiet wins over the timeout in the same cycle.
        if (quiet) begin
          sel_d   = tgt_q;
          state_d = StSwitch;
        end else if (tmr_limit) begin
          err_d   = 1'b1;
          state_d = StIdle;
        end else begin
          tmr_inc = 1'b1;
        end
      end
      StSwitch: begin
        tmr_load = 1'b1;
        state_d  = StSettle;
      end
      StSettle: begin
        if (tmr_zero) begin
          state_d = StDone;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State, latched target, mux select and error pulse registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      tgt_q   <= CHAIN_BUF;
      sel_q   <= CHAIN_BUF;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tgt_q   <= tgt_d;
      sel_q   <= sel_d;
      err_q   <= err_d;
    end
  end

  // Outputs decoded from state; capture is gated while the new chain settles.
  always_comb begin
    sel      = sel_q;
    err      = err_q;
    busy     = (state_q != StIdle);
    swap_ack = (state_q == StDone);
    cap_en   = cap_mask;
    if ((state_q == StSwitch) || (state_q == StSettle)) begin
      cap_en = '0;
    end
  end

endmodule

// File: tb/tb_chain_swap_ctrl.sv
// Scoreboard bench for chain_swap_ctrl: expected ack/err events are queued
// when a request is driven and matched when the DUT pulses them.
module tb_chain_swap_ctrl;

  localparam int unsigned NCap    = 11;
  localparam int unsigned Settle  = 2;
  localparam int unsigned QuietTo = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic            swap_req;
  logic            swap_to;
  logic            quiet;
  logic [NCap-1:0] cap_mask;
  logic            sel;
  logic [NCap-1:0] cap_en;
  logic            busy;
  logic            swap_ack;
  logic            err;

  chain_swap_ctrl #(
    .N_CAP         (NCap),
    .SETTLE        (Settle),
    .QUIET_TIMEOUT (QuietTo)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .swap_req (swap_req),
    .swap_to  (swap_to),
    .quiet    (quiet),
    .cap_mask (cap_mask),
    .sel      (sel),
    .cap_en   (cap_en),
    .busy     (busy),
    .swap_ack (swap_ack),
    .err      (err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    bit is_err;
    int at;
    bit sel;
  } ev_t;

  ev_t exp_q[$];
  ev_t mon_e;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_ev(input bit is_err, input int at, input bit s);
    ev_t e;
    e.is_err = is_err;
    e.at     = at;
    e.sel    = s;
    exp_q.push_back(e);
  endtask

  // Match every ack/err pulse against the next queued expectation.
  always @(negedge clk) begin
    if (swap_ack || err) begin
      if (exp_q.size() == 0) begin
        check("unexpected_event", {30'd0, err, swap_ack}, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("event_kind", {30'd0, swap_ack, err}, mon_e.is_err ? 32'd1 : 32'd2);
        check("event_cycle", cyc, mon_e.at);
        check("event_sel", {31'd0, sel}, {31'd0, mon_e.sel});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    bit gate_seen;
    bit sel_moved;
    bit busy_drop;

    rst      = 1'b1;
    swap_req = 1'b0;
    swap_to  = 1'b0;
    quiet    = 1'b0;
    cap_mask = 11'h7FF;
    repeat (3) tick();
    rst = 1'b0;
    check("rst_sel", {31'd0, sel}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_cap_en", {21'd0, cap_en}, 32'h7FF);
    check("rst_ack", {31'd0, swap_ack}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    repeat (2) tick();

    // Real swap to inverter chain, quiet immediately.
    n = cyc;
    swap_req = 1'b1; swap_to = 1'b1; quiet = 1'b1;
    push_ev(1'b0, n + 5, 1'b1);
    tick();
    swap_req = 1'b0;
    check("s1_drain_busy", {31'd0, busy}, 32'd1);
    check("s1_drain_cap", {21'd0, cap_en}, 32'h7FF);
    check("s1_drain_sel", {31'd0, sel}, 32'd0);
    tick();
    check("s1_switch_sel", {31'd0, sel}, 32'd1);
    check("s1_switch_cap", {21'd0, cap_en}, 32'd0);
    tick();
    check("s1_settle0_cap", {21'd0, cap_en}, 32'd0);
    tick();
    check("s1_settle1_cap", {21'd0, cap_en}, 32'd0);
    tick();
    check("s1_done_cap", {21'd0, cap_en}, 32'h7FF);
    check("s1_done_ack", {31'd0, swap_ack}, 32'd1);
    tick();
    check("s1_idle_busy", {31'd0, busy}, 32'd0);
    check("s1_idle_sel", {31'd0, sel}, 32'd1);

    // Swap back with quiet low for four DRAIN cycles.
    n = cyc;
    swap_req = 1'b1; swap_to = 1'b0; quiet = 1'b0;
    push_ev(1'b0, n + 9, 1'b0);
    tick();
    swap_req = 1'b0; swap_to = 1'b1;
    repeat (3) tick();
    check("s2_wait_busy", {31'd0, busy}, 32'd1);
    check("s2_wait_sel", {31'd0, sel}, 32'd1);
    tick();
    quiet = 1'b1;
    check("s2_drain_cap", {21'd0, cap_en}, 32'h7FF);
    tick();
    quiet = 1'b0;
    check("s2_switch_sel", {31'd0, sel}, 32'd0);
    check("s2_switch_cap", {21'd0, cap_en}, 32'd0);
    repeat (3) tick();
    check("s2_done_ack", {31'd0, swap_ack}, 32'd1);
    check("s2_done_cap", {21'd0, cap_en}, 32'h7FF);
    tick();

    // Quiet stuck low: timeout.
    n = cyc;
    swap_req = 1'b1; swap_to = 1'b1; quiet = 1'b0;
    push_ev(1'b1, n + QuietTo + 1, 1'b0);
    gate_seen = 1'b0; sel_moved = 1'b0; busy_drop = 1'b0;
    tick();
    swap_req = 1'b0;
    for (int i = 1; i <= int'(QuietTo); i++) begin
      if (cap_en !== 11'h7FF) gate_seen = 1'b1;
      if (sel !== 1'b0) sel_moved = 1'b1;
      if (busy !== 1'b1) busy_drop = 1'b1;
      tick();
    end
    check("s3_err", {31'd0, err}, 32'd1);
    check("s3_err_busy", {31'd0, busy}, 32'd0);
    check("s3_sel", {31'd0, sel}, 32'd0);
    check("s3_gate_seen", {31'd0, gate_seen}, 32'd0);
    check("s3_sel_moved", {31'd0, sel_moved}, 32'd0);
    check("s3_busy_drop", {31'd0, busy_drop}, 32'd0);
    tick();
    check("s3_err_pulse", {31'd0, err}, 32'd0);

    // No-op swap: target already selected.
    n = cyc;
    swap_req = 1'b1; swap_to = 1'b0;
    push_ev(1'b0, n + 1, 1'b0);
    tick();
    swap_req = 1'b0;
    check("s4_busy", {31'd0, busy}, 32'd1);
    check("s4_cap", {21'd0, cap_en}, 32'h7FF);
    check("s4_sel", {31'd0, sel}, 32'd0);
    tick();
    check("s4_busy_after", {31'd0, busy}, 32'd0);

    // Reset during SETTLE after switching to the inverter chain.
    swap_req = 1'b1; swap_to = 1'b1; quiet = 1'b1;
    tick();
    swap_req = 1'b0;
    tick();
    check("s5_switch_sel", {31'd0, sel}, 32'd1);
    tick();
    check("s5_settle_cap", {21'd0, cap_en}, 32'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("s5_rst_sel", {31'd0, sel}, 32'd0);
    check("s5_rst_cap", {21'd0, cap_en}, 32'h7FF);
    check("s5_rst_busy", {31'd0, busy}, 32'd0);
    check("s5_rst_ack", {31'd0, swap_ack}, 32'd0);
    repeat (4) tick();

    // Partial capture mask through a real swap.
    cap_mask = 11'h0F0;
    n = cyc;
    swap_req = 1'b1; swap_to = 1'b1; quiet = 1'b1;
    push_ev(1'b0, n + 5, 1'b1);
    tick();
    swap_req = 1'b0;
    check("s6_drain_cap", {21'd0, cap_en}, 32'h0F0);
    for (int i = 2; i <= 4; i++) begin
      tick();
      check("s6_gate_cap", {21'd0, cap_en}, 32'h000);
    end
    tick();
    check("s6_done_cap", {21'd0, cap_en}, 32'h0F0);
    tick();
    check("s6_idle_cap", {21'd0, cap_en}, 32'h0F0);
    check("s6_idle_busy", {31'd0, busy}, 32'd0);

    // Held request on the current chain: no-op ack every two cycles.
    n = cyc;
    swap_req = 1'b1; swap_to = 1'b1;
    push_ev(1'b0, n + 1, 1'b1);
    push_ev(1'b0, n + 3, 1'b1);
    tick();
    tick();
    check("s7_gap_busy", {31'd0, busy}, 32'd0);
    tick();
    swap_req = 1'b0;
    repeat (3) tick();

    check("queue_drained", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
